// File: rtl/ram_arbiter.sv
// Two-master arbiter in front of a single-outstanding RAM slave port.
// Round-robin on contention, with the grant held while a request is stalled.
//
// state | meaning
// IDLE  | no transaction outstanding; grant drives the slave request port
// BUSY  | one request accepted; response routed to owner
module ram_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_we_i,
    input  logic        m0_req_valid_i,
    output logic        m0_req_ready_o,
    output logic        m0_rsp_valid_o,
    input  logic        m0_rsp_ready_i,
    output logic [31:0] m0_data_o,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_we_i,
    input  logic        m1_req_valid_i,
    output logic        m1_req_ready_o,
    output logic        m1_rsp_valid_o,
    input  logic        m1_rsp_ready_i,
    output logic [31:0] m1_data_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_data_o,
    output logic [3:0]  s_sel_o,
    output logic        s_we_o,
    output logic        s_req_valid_o,
    input  logic        s_req_ready_i,
    input  logic        s_rsp_valid_i,
    output logic        s_rsp_ready_o,
    input  logic [31:0] s_data_i
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t state;
    logic   lock;
    logic   lock_m;
    logic   owner;
    logic   last_owner;
    logic   gnt;
    logic   idle;
    logic   busy;

    // Outputs are gated by rst_n so they read zero while reset is held.
    assign idle = rst_n && (state == IDLE);
    assign busy = rst_n && (state == BUSY);

    always_comb begin
        gnt = 1'b0;
        if (lock)
            gnt = lock_m;
        else if (m0_req_valid_i && !m1_req_valid_i)
            gnt = 1'b0;
        else if (m1_req_valid_i && !m0_req_valid_i)
            gnt = 1'b1;
        else if (m0_req_valid_i && m1_req_valid_i)
            gnt = ~last_owner;
    end

    always_comb begin
        s_req_valid_o  = 1'b0;
        s_addr_o       = '0;
        s_data_o       = '0;
        s_sel_o        = '0;
        s_we_o         = 1'b0;
        s_rsp_ready_o  = 1'b0;
        m0_req_ready_o = 1'b0;
        m1_req_ready_o = 1'b0;
        m0_rsp_valid_o = 1'b0;
        m1_rsp_valid_o = 1'b0;
        m0_data_o      = '0;
        m1_data_o      = '0;
        if (idle) begin
            s_req_valid_o  = gnt ? m1_req_valid_i : m0_req_valid_i;
            s_addr_o       = gnt ? m1_addr_i : m0_addr_i;
            s_data_o       = gnt ? m1_data_i : m0_data_i;
            s_sel_o        = gnt ? m1_sel_i : m0_sel_i;
            s_we_o         = gnt ? m1_we_i : m0_we_i;
            m0_req_ready_o = !gnt && s_req_ready_i;
            m1_req_ready_o = gnt && s_req_ready_i;
        end else if (busy) begin
            s_rsp_ready_o  = owner ? m1_rsp_ready_i : m0_rsp_ready_i;
            m0_rsp_valid_o = !owner && s_rsp_valid_i;
            m1_rsp_valid_o = owner && s_rsp_valid_i;
            m0_data_o      = owner ? '0 : s_data_i;
            m1_data_o      = owner ? s_data_i : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lock       <= 1'b0;
            lock_m     <= 1'b0;
            owner      <= 1'b0;
            last_owner <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (s_req_valid_o && s_req_ready_i) begin
                        owner <= gnt;
                        lock  <= 1'b0;
                        state <= BUSY;
                    end else if (s_req_valid_o) begin
                        lock   <= 1'b1;
                        lock_m <= gnt;
                    end
                end
                BUSY: begin
                    if (s_rsp_valid_i && s_rsp_ready_o) begin
                        last_owner <= owner;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against a transaction-level reference model.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] m0_addr_i, m0_data_i, m1_addr_i, m1_data_i;
    logic [3:0]  m0_sel_i, m1_sel_i;
    logic        m0_we_i, m0_req_valid_i, m0_rsp_ready_i;
    logic        m1_we_i, m1_req_valid_i, m1_rsp_ready_i;
    logic        m0_req_ready_o, m0_rsp_valid_o, m1_req_ready_o, m1_rsp_valid_o;
    logic [31:0] m0_data_o, m1_data_o;
    logic [31:0] s_addr_o, s_data_o, s_data_i;
    logic [3:0]  s_sel_o;
    logic        s_we_o, s_req_valid_o, s_req_ready_i, s_rsp_valid_i, s_rsp_ready_o;

    int checks = 0;
    int failures = 0;

    wire [138:0] all_out = {m0_req_ready_o, m0_rsp_valid_o, m0_data_o,
                            m1_req_ready_o, m1_rsp_valid_o, m1_data_o,
                            s_addr_o, s_data_o, s_sel_o, s_we_o,
                            s_req_valid_o, s_rsp_ready_o};
    wire [68:0] req_fields = {s_addr_o, s_data_o, s_sel_o, s_we_o};

    ram_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_sel_i(m0_sel_i),
        .m0_we_i(m0_we_i), .m0_req_valid_i(m0_req_valid_i),
        .m0_req_ready_o(m0_req_ready_o), .m0_rsp_valid_o(m0_rsp_valid_o),
        .m0_rsp_ready_i(m0_rsp_ready_i), .m0_data_o(m0_data_o),
        .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_sel_i(m1_sel_i),
        .m1_we_i(m1_we_i), .m1_req_valid_i(m1_req_valid_i),
        .m1_req_ready_o(m1_req_ready_o), .m1_rsp_valid_o(m1_rsp_valid_o),
        .m1_rsp_ready_i(m1_rsp_ready_i), .m1_data_o(m1_data_o),
        .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_sel_o(s_sel_o),
        .s_we_o(s_we_o), .s_req_valid_o(s_req_valid_o),
        .s_req_ready_i(s_req_ready_i), .s_rsp_valid_i(s_rsp_valid_i),
        .s_rsp_ready_o(s_rsp_ready_o), .s_data_i(s_data_i)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        m0_addr_i = '0; m0_data_i = '0; m0_sel_i = '0; m0_we_i = 1'b0;
        m0_req_valid_i = 1'b0; m0_rsp_ready_i = 1'b0;
        m1_addr_i = '0; m1_data_i = '0; m1_sel_i = '0; m1_we_i = 1'b0;
        m1_req_valid_i = 1'b0; m1_rsp_ready_i = 1'b0;
        s_req_ready_i = 1'b0; s_rsp_valid_i = 1'b0; s_data_i = '0;
    endtask

    // Leaves the bench at a falling edge, reset released, inputs idle.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            m0_addr_i = $urandom; m0_data_i = $urandom; m0_sel_i = 4'($urandom);
            m0_we_i = 1'($urandom); m0_req_valid_i = 1'b1; m0_rsp_ready_i = 1'b1;
            m1_addr_i = $urandom; m1_data_i = $urandom; m1_sel_i = 4'($urandom);
            m1_we_i = 1'($urandom); m1_req_valid_i = 1'b1; m1_rsp_ready_i = 1'b1;
            s_req_ready_i = 1'b1; s_rsp_valid_i = 1'b1; s_data_i = $urandom;
            #1;
            checks++;
            if (all_out !== '0) begin
                failures++; $display("FAIL reset_outputs_zero: got %h exp 0", all_out);
            end
        end
        do_reset();
    endtask

    task automatic test_basic_read();
        do_reset();
        m0_addr_i = 32'h10; m0_req_valid_i = 1'b1; s_req_ready_i = 1'b1;
        #1;
        checks++;
        if (s_req_valid_o !== 1'b1 || s_addr_o !== 32'h10 || m0_req_ready_o !== 1'b1) begin
            failures++; $display("FAIL read_accept: got v=%b a=%h rdy=%b exp v=1 a=10 rdy=1", s_req_valid_o, s_addr_o, m0_req_ready_o);
        end
        @(negedge clk);
        m0_req_valid_i = 1'b0; s_req_ready_i = 1'b0;
        s_rsp_valid_i = 1'b1; s_data_i = 32'hDEADBEEF; m0_rsp_ready_i = 1'b1;
        #1;
        checks++;
        if (m0_rsp_valid_o !== 1'b1 || m0_data_o !== 32'hDEADBEEF || m1_rsp_valid_o !== 1'b0) begin
            failures++; $display("FAIL read_response: got v0=%b d0=%h v1=%b exp 1 deadbeef 0", m0_rsp_valid_o, m0_data_o, m1_rsp_valid_o);
        end
        checks++;
        if (s_rsp_ready_o !== 1'b1 || s_req_valid_o !== 1'b0) begin
            failures++; $display("FAIL read_busy_port: got rr=%b qv=%b exp 1 0", s_rsp_ready_o, s_req_valid_o);
        end
        @(negedge clk);
        s_rsp_valid_i = 1'b0;
        #1;
        checks++;
        if (m0_rsp_valid_o !== 1'b0 || m0_data_o !== 32'h0) begin
            failures++; $display("FAIL read_back_idle: got v=%b d=%h exp 0 0", m0_rsp_valid_o, m0_data_o);
        end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        bit exp_m1;
        do_reset();
        m0_addr_i = 32'hA0; m1_addr_i = 32'hB0;
        m0_req_valid_i = 1'b1; m1_req_valid_i = 1'b1;
        m0_rsp_ready_i = 1'b1; m1_rsp_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_m1 = (i % 2) == 1;
            s_req_ready_i = 1'b1; s_rsp_valid_i = 1'b0;
            #1;
            checks++;
            if (s_addr_o !== (exp_m1 ? 32'hB0 : 32'hA0) || m0_req_ready_o !== !exp_m1 || m1_req_ready_o !== exp_m1) begin
                failures++; $display("FAIL rr_grant%0d: got a=%h r0=%b r1=%b exp m%0d", i, s_addr_o, m0_req_ready_o, m1_req_ready_o, exp_m1);
            end
            @(negedge clk);
            s_req_ready_i = 1'b0; s_rsp_valid_i = 1'b1; s_data_i = 32'(i);
            #1;
            checks++;
            if (m1_rsp_valid_o !== exp_m1 || m0_rsp_valid_o !== !exp_m1) begin
                failures++; $display("FAIL rr_resp%0d: got v0=%b v1=%b exp m%0d", i, m0_rsp_valid_o, m1_rsp_valid_o, exp_m1);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_lock();
        do_reset();
        m1_addr_i = 32'h111; m1_req_valid_i = 1'b1; m0_addr_i = 32'h222;
        for (int c = 1; c <= 4; c++) begin
            if (c >= 2) m0_req_valid_i = 1'b1;
            s_req_ready_i = (c == 4);
            #1;
            checks++;
            if (s_req_valid_o !== 1'b1 || s_addr_o !== 32'h111 || m0_req_ready_o !== 1'b0 || m1_req_ready_o !== (c == 4)) begin
                failures++; $display("FAIL lock_cycle%0d: got v=%b a=%h r0=%b r1=%b exp 1 111 0 %0d", c, s_req_valid_o, s_addr_o, m0_req_ready_o, m1_req_ready_o, c == 4);
            end
            @(negedge clk);
        end
        m1_req_valid_i = 1'b0; s_req_ready_i = 1'b0;
        #1;
        checks++;
        if (s_req_valid_o !== 1'b0 || m0_req_ready_o !== 1'b0) begin
            failures++; $display("FAIL lock_busy: got v=%b r0=%b exp 0 0", s_req_valid_o, m0_req_ready_o);
        end
        @(negedge clk);
    endtask

    task automatic test_write_backpressure();
        do_reset();
        m0_addr_i = 32'h40; m0_data_i = 32'h12345678; m0_sel_i = 4'hF; m0_we_i = 1'b1;
        m0_req_valid_i = 1'b1; s_req_ready_i = 1'b1;
        #1;
        checks++;
        if (req_fields !== {32'h40, 32'h12345678, 4'hF, 1'b1} || m0_req_ready_o !== 1'b1) begin
            failures++; $display("FAIL wr_fields: got %h rdy=%b", req_fields, m0_req_ready_o);
        end
        @(negedge clk);
        m0_req_valid_i = 1'b0; m1_req_valid_i = 1'b1; m1_addr_i = 32'h50;
        s_rsp_valid_i = 1'b1; m0_rsp_ready_i = 1'b0; m1_rsp_ready_i = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (s_rsp_ready_o !== 1'b0 || m0_rsp_valid_o !== 1'b1 || m1_req_ready_o !== 1'b0 || s_req_valid_o !== 1'b0) begin
                failures++; $display("FAIL wr_stall%0d: got rr=%b v0=%b r1=%b qv=%b exp 0 1 0 0", c, s_rsp_ready_o, m0_rsp_valid_o, m1_req_ready_o, s_req_valid_o);
            end
            @(negedge clk);
        end
        m0_rsp_ready_i = 1'b1;
        #1;
        checks++;
        if (s_rsp_ready_o !== 1'b1 || m1_req_ready_o !== 1'b0) begin
            failures++; $display("FAIL wr_release: got rr=%b r1=%b exp 1 0", s_rsp_ready_o, m1_req_ready_o);
        end
        @(negedge clk);
        s_rsp_valid_i = 1'b0;
        #1;
        checks++;
        if (s_req_valid_o !== 1'b1 || s_addr_o !== 32'h50 || m1_req_ready_o !== 1'b1) begin
            failures++; $display("FAIL wr_next_grant: got v=%b a=%h r1=%b exp 1 50 1", s_req_valid_o, s_addr_o, m1_req_ready_o);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_busy();
        do_reset();
        m0_addr_i = 32'h300; m0_req_valid_i = 1'b1; s_req_ready_i = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        m1_addr_i = 32'h400; m1_req_valid_i = 1'b1;
        s_rsp_valid_i = 1'b1; s_data_i = 32'hCAFE0001;
        m0_rsp_ready_i = 1'b1; m1_rsp_ready_i = 1'b1;
        #1;
        checks++;
        if (all_out !== '0) begin
            failures++; $display("FAIL rst_busy_zero: got %h exp 0", all_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (m0_rsp_valid_o !== 1'b0 || s_addr_o !== 32'h300 || m0_req_ready_o !== 1'b1 || m1_req_ready_o !== 1'b0) begin
            failures++; $display("FAIL rst_busy_after: got v0=%b a=%h r0=%b r1=%b exp 0 300 1 0", m0_rsp_valid_o, s_addr_o, m0_req_ready_o, m1_req_ready_o);
        end
        @(negedge clk);
    endtask

    task automatic test_spurious();
        do_reset();
        s_rsp_valid_i = 1'b1; s_data_i = 32'h55AA55AA;
        m0_rsp_ready_i = 1'b1; m1_rsp_ready_i = 1'b1;
        #1;
        checks++;
        if (m0_rsp_valid_o !== 1'b0 || m1_rsp_valid_o !== 1'b0 || s_rsp_ready_o !== 1'b0 || m0_data_o !== 32'h0 || m1_data_o !== 32'h0) begin
            failures++; $display("FAIL spurious_rsp: got v0=%b v1=%b rr=%b exp 0 0 0", m0_rsp_valid_o, m1_rsp_valid_o, s_rsp_ready_o);
        end
        @(negedge clk);
        s_rsp_valid_i = 1'b0; m1_addr_i = 32'h77; m1_req_valid_i = 1'b1; s_req_ready_i = 1'b1;
        #1;
        checks++;
        if (s_req_valid_o !== 1'b1 || m1_req_ready_o !== 1'b1 || s_addr_o !== 32'h77) begin
            failures++; $display("FAIL spurious_still_idle: got v=%b r1=%b a=%h exp 1 1 77", s_req_valid_o, m1_req_ready_o, s_addr_o);
        end
        @(negedge clk);
    endtask

    // Reference model: one pending request per master, at most one
    // transaction in flight, grant rules applied at transaction level.
    task automatic test_random(int n);
        bit          pend[2];
        logic [31:0] a[2], d[2];
        logic [3:0]  s[2];
        logic        w[2];
        bit          m_busy = 0;
        int          m_lock = -1;
        int          m_owner = 0;
        int          m_last = 1;
        int          g;
        bit          exp_v, rr;
        int          errs_before = failures;
        do_reset();
        pend[0] = 0; pend[1] = 0;
        for (int cyc = 0; cyc < n; cyc++) begin
            for (int m = 0; m < 2; m++) begin
                if (!pend[m] && $urandom_range(0, 2) == 0) begin
                    pend[m] = 1; a[m] = $urandom; d[m] = $urandom;
                    s[m] = 4'($urandom); w[m] = 1'($urandom);
                end
            end
            m0_req_valid_i = pend[0]; m0_addr_i = a[0]; m0_data_i = d[0]; m0_sel_i = s[0]; m0_we_i = w[0];
            m1_req_valid_i = pend[1]; m1_addr_i = a[1]; m1_data_i = d[1]; m1_sel_i = s[1]; m1_we_i = w[1];
            s_req_ready_i = 1'($urandom); s_rsp_valid_i = 1'($urandom); s_data_i = $urandom;
            m0_rsp_ready_i = 1'($urandom); m1_rsp_ready_i = 1'($urandom);
            #1;
            if (!m_busy) begin
                if (m_lock >= 0) g = m_lock;
                else if (pend[0] && !pend[1]) g = 0;
                else if (pend[1] && !pend[0]) g = 1;
                else if (pend[0] && pend[1]) g = 1 - m_last;
                else g = -1;
                exp_v = (g >= 0) && pend[g];
                checks++;
                if (s_req_valid_o !== exp_v) begin
                    failures++; $display("FAIL rnd_req_valid c%0d: got %b exp %b", cyc, s_req_valid_o, exp_v);
                end
                if (exp_v) begin
                    checks++;
                    if (req_fields !== {a[g], d[g], s[g], w[g]}) begin
                        failures++; $display("FAIL rnd_fields c%0d: got %h exp %h", cyc, req_fields, {a[g], d[g], s[g], w[g]});
                    end
                    checks++;
                    if (m0_req_ready_o !== (g == 0 && s_req_ready_i) || m1_req_ready_o !== (g == 1 && s_req_ready_i)) begin
                        failures++; $display("FAIL rnd_req_ready c%0d: got %b%b exp grant m%0d rdy %b", cyc, m0_req_ready_o, m1_req_ready_o, g, s_req_ready_i);
                    end
                end
                checks++;
                if ({m0_rsp_valid_o, m1_rsp_valid_o, s_rsp_ready_o} !== 3'b000) begin
                    failures++; $display("FAIL rnd_idle_rsp c%0d: got %b%b%b exp 000", cyc, m0_rsp_valid_o, m1_rsp_valid_o, s_rsp_ready_o);
                end
                if (exp_v && s_req_ready_i) begin
                    m_busy = 1; m_owner = g; m_lock = -1; pend[g] = 0;
                end else if (exp_v) begin
                    m_lock = g;
                end
            end else begin
                rr = (m_owner == 0) ? m0_rsp_ready_i : m1_rsp_ready_i;
                checks++;
                if (s_req_valid_o !== 1'b0 || m0_req_ready_o !== 1'b0 || m1_req_ready_o !== 1'b0 || req_fields !== '0) begin
                    failures++; $display("FAIL rnd_busy_req c%0d: got v=%b r=%b%b f=%h exp all 0", cyc, s_req_valid_o, m0_req_ready_o, m1_req_ready_o, req_fields);
                end
                checks++;
                if (s_rsp_ready_o !== rr) begin
                    failures++; $display("FAIL rnd_rsp_ready c%0d: got %b exp %b", cyc, s_rsp_ready_o, rr);
                end
                checks++;
                if (m0_rsp_valid_o !== (m_owner == 0 && s_rsp_valid_i) || m1_rsp_valid_o !== (m_owner == 1 && s_rsp_valid_i)) begin
                    failures++; $display("FAIL rnd_rsp_valid c%0d: got %b%b exp owner m%0d v %b", cyc, m0_rsp_valid_o, m1_rsp_valid_o, m_owner, s_rsp_valid_i);
                end
                checks++;
                if (m0_data_o !== (m_owner == 0 ? s_data_i : 32'h0) || m1_data_o !== (m_owner == 1 ? s_data_i : 32'h0)) begin
                    failures++; $display("FAIL rnd_rsp_data c%0d: got %h %h exp owner m%0d data %h", cyc, m0_data_o, m1_data_o, m_owner, s_data_i);
                end
                if (s_rsp_valid_i && rr) begin
                    m_busy = 0; m_last = m_owner;
                end
            end
            if (failures - errs_before > 10) break;
            @(negedge clk);
        end
        clear_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_basic_read();
        test_round_robin();
        test_lock();
        test_write_backpressure();
        test_reset_busy();
        test_spurious();
        test_random(2000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
